// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the VRAM arbitration slice of the cpu:
//   - VRAM geometry (word address width, word width)
//   - arbiter FSM state encoding
//   - grant-source encoding used by the arbiter datapath
//   - helper to size a counter that must reach a given maximum value
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned VRAM_ADDR_WIDTH = 13;
    localparam int unsigned VRAM_DATA_WIDTH = 16;

    // ST_CPU_ACK lasts exactly one cycle and masks the CPU so a held
    // cpu_req cannot issue twice for one transaction.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CPU_ACK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_src_e;

    // Bits needed to hold values 0..max_val inclusive (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at MAX_VAL, with a synchronous clear.
// Clear (or reset) wins over increment.
//
// Ports:
//   i_clk    in   clock
//   i_reset  in   synchronous active-high reset (count -> 0)
//   i_clear  in   synchronous clear (count -> 0)
//   i_inc    in   increment request, ignored once MAX_VAL is reached
//   o_count  out  current count
// -----------------------------------------------------------------------------
module sat_counter
    import cpu_pkg::*;
#(
    parameter int unsigned         WIDTH   = 8,
    parameter logic [WIDTH-1:0]    MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == MAX_VAL);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM (1-cycle read latency) between the
// VGA scanout fetcher and the CPU load/store path. VGA wins every cycle unless
// the CPU has been denied CPU_MAX_WAIT consecutive eligible cycles, in which
// case the CPU takes the slot and the VGA request is reported as a miss.
//
// Arbitration and the RAM-side mux are combinational in cycle N; the RAM
// samples at the end of N and all responses appear in N+1.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   vga_req/vga_addr          single-cycle VGA fetch request
//   vga_data/vga_valid        fetched word, cycle after a VGA grant
//   vga_miss                  VGA request of the previous cycle was dropped
//   cpu_req/we/addr/wdata     CPU access, cpu_req held until cpu_ack
//   cpu_rdata/cpu_ack         single-cycle completion (+ read data)
//   mem_addr/we/wdata/rdata   VRAM port
//   miss_count                saturating count of vga_miss pulses
// -----------------------------------------------------------------------------
module vram_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = VRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = VRAM_DATA_WIDTH,
    parameter int unsigned CPU_MAX_WAIT   = 8,
    parameter int unsigned MISS_CNT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    // VGA fetch port
    input  logic                      vga_req,
    input  logic [ADDR_WIDTH-1:0]     vga_addr,
    output logic [DATA_WIDTH-1:0]     vga_data,
    output logic                      vga_valid,
    output logic                      vga_miss,
    // CPU port
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    output logic [DATA_WIDTH-1:0]     cpu_rdata,
    output logic                      cpu_ack,
    // VRAM port
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    // Statistics
    output logic [MISS_CNT_WIDTH-1:0] miss_count
);

    localparam int unsigned            STARVE_W   = cnt_width(CPU_MAX_WAIT);
    localparam logic [STARVE_W-1:0]    STARVE_MAX = STARVE_W'(CPU_MAX_WAIT);

    arb_state_e              r_state;
    logic                    r_vga_valid;
    logic                    r_vga_miss;
    logic                    r_cpu_ack;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;

    logic                    w_cpu_ok;
    logic                    w_starved;
    gnt_src_e                w_gnt;
    logic                    w_gnt_cpu;
    logic                    w_gnt_vga;
    logic                    w_miss_now;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [STARVE_W-1:0]     w_starve;
    logic                    w_starve_inc;
    logic                    w_starve_clr;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    assign w_cpu_ok  = cpu_req && (r_state == ST_IDLE);
    assign w_starved = (w_starve == STARVE_MAX);

    always_comb begin
        w_gnt = GNT_NONE;
        if (vga_req && !(w_cpu_ok && w_starved)) begin
            w_gnt = GNT_VGA;
        end else if (w_cpu_ok) begin
            w_gnt = GNT_CPU;
        end
    end

    assign w_gnt_cpu  = (w_gnt == GNT_CPU);
    assign w_gnt_vga  = (w_gnt == GNT_VGA);
    assign w_miss_now = vga_req && w_gnt_cpu;

    // RAM-side mux; with no grant the address parks on its last value.
    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = '0;
        unique case (w_gnt)
            GNT_VGA: begin
                w_mem_addr = vga_addr;
            end
            GNT_CPU: begin
                w_mem_addr  = cpu_addr;
                w_mem_wdata = cpu_wdata;
            end
            default: begin
                w_mem_addr = r_mem_addr;
            end
        endcase
    end

    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    // A CPU write granted in the reset cycle must not reach the RAM.
    assign mem_we    = w_gnt_cpu && cpu_we && !i_reset;

    // ---------------------------------------------------------------------
    // Starvation guard: counts eligible-but-denied CPU cycles
    // ---------------------------------------------------------------------
    assign w_starve_inc = w_cpu_ok && !w_gnt_cpu;
    assign w_starve_clr = w_gnt_cpu || !cpu_req;

    sat_counter #(
        .WIDTH   (STARVE_W),
        .MAX_VAL (STARVE_MAX)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_starve_clr),
        .i_inc   (w_starve_inc),
        .o_count (w_starve)
    );

    // Counts in the same cycle the miss is decided so miss_count and the
    // vga_miss pulse become visible together.
    sat_counter #(
        .WIDTH   (MISS_CNT_WIDTH),
        .MAX_VAL ({MISS_CNT_WIDTH{1'b1}})
    ) u_miss_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (1'b0),
        .i_inc   (w_miss_now),
        .o_count (miss_count)
    );

    // ---------------------------------------------------------------------
    // FSM and registered response flags
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_vga_valid <= 1'b0;
            r_vga_miss  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_vga_valid <= w_gnt_vga;
            r_vga_miss  <= w_miss_now;
            r_cpu_ack   <= w_gnt_cpu;
            r_mem_addr  <= w_mem_addr;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt_cpu) begin
                        r_state <= ST_CPU_ACK;
                    end
                end
                ST_CPU_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM output is already registered; gate it so idle data reads as zero.
    assign vga_valid = r_vga_valid;
    assign vga_miss  = r_vga_miss;
    assign cpu_ack   = r_cpu_ack;
    assign vga_data  = r_vga_valid ? mem_rdata : '0;
    assign cpu_rdata = r_cpu_ack   ? mem_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the VGA scanout fetcher and the CPU load/store path.
- VGA has priority every cycle. A starvation guard gives the CPU a guaranteed slot after a bounded wait.
- Sits inside cpu, between the core's memory-mapped VRAM window, the VGA timing/pixel unit and the VRAM block RAM.
- RAM read latency is 1 cycle.

Parameters:
- ADDR_WIDTH, 13, VRAM word address width.
- DATA_WIDTH, 16, VRAM word width.
- CPU_MAX_WAIT, 8, consecutive denied CPU cycles before the CPU wins arbitration over VGA (must be >= 1).
- MISS_CNT_WIDTH, 16, width of the saturating VGA miss counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- vga_req  in  1  VGA fetch request for this cycle (single-cycle, no hold).
- vga_addr  in  ADDR_WIDTH  VGA fetch address.
- vga_data  out  DATA_WIDTH  fetched word, valid when vga_valid.
- vga_valid  out  1  VGA data valid (cycle after grant).
- vga_miss  out  1  pulse: the VGA request of the previous cycle was dropped.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  CPU read data, valid when cpu_ack.
- cpu_ack  out  1  single-cycle completion.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data (1-cycle latency).
- miss_count  out  MISS_CNT_WIDTH  saturating count of vga_miss pulses.

Behaviour:
- Clock and reset: single clock i_clk; reset i_reset is synchronous, active-high.
- Arbitration is combinational in cycle N. mem_addr, mem_we and mem_wdata are muxed from the winner in cycle N. RAM samples at the end of N. Response is registered and visible in N+1.
- FSM:
  - ST_IDLE: the CPU is eligible for grant.
  - ST_CPU_ACK: entered for exactly one cycle after a CPU grant. The CPU is masked here, so a held cpu_req cannot double-issue. Always returns to ST_IDLE.
- CPU throughput is at most one access per 2 cycles.
- Grant rules (cpu_ok = cpu_req & state==ST_IDLE):
  - vga_req & !(cpu_ok & starve==CPU_MAX_WAIT) -> grant VGA.
  - else cpu_ok -> grant CPU.
  - else no grant: mem_we=0, mem_addr holds its last value.
- Starvation counter starve:
  - Increments (saturating at CPU_MAX_WAIT) each cycle cpu_ok is true and the CPU is not granted.
  - Clears to 0 on CPU grant or when cpu_req is low.
- mem_we = CPU grant & cpu_we & !i_reset.
- N+1 outputs:
  - vga_valid=1 and vga_data=mem_rdata if VGA was granted in N.
  - vga_miss=1 if vga_req was high in N but the CPU won.
  - cpu_ack=1 if the CPU was granted in N. cpu_rdata=mem_rdata for reads; cpu_rdata is don't-care for writes (drive mem_rdata).
- miss_count increments on each vga_miss and saturates at all-ones.
- No VGA grant is ever dropped silently: every vga_req produces exactly one of vga_valid or vga_miss in the next cycle.
- Reset, in any state:
  - Next cycle: state=ST_IDLE, starve=0, vga_valid=0, vga_miss=0, cpu_ack=0, miss_count=0. vga_data, cpu_rdata and mem_addr reset to 0.
  - A CPU access granted in the reset cycle is not written (mem_we gated) and is not acked. The CPU must re-request after reset.

Decomposition:
- Shared package cpu_pkg: VRAM_ADDR_WIDTH, VRAM_DATA_WIDTH, the state encodings ST_IDLE/ST_CPU_ACK, and a grant-source enum GNT_NONE/GNT_VGA/GNT_CPU.
- One natural sub-module: sat_counter (parameterised width, inc, sync clear), used for both starve and miss_count.

Test Plan:
- CPU write then read, no VGA:
  - cpu_req=1, we=1, addr=0x0010, wdata=0xBEEF -> mem_we=1 in the request cycle, cpu_ack=1 next cycle.
  - Then read 0x0010 -> cpu_ack with cpu_rdata=0xBEEF one cycle after grant.
- VGA stream: vga_req every cycle, addr 0..7, RAM preloaded with addr^0x5A5A -> vga_valid high 8 consecutive cycles, each one cycle late, data matches, vga_miss never set.
- Starvation, CPU_MAX_WAIT=8:
  - vga_req constant and cpu read held from cycle 0 -> CPU denied cycles 0-7, granted cycle 8.
  - Cycle 9: cpu_ack=1, vga_miss=1, vga_valid=0.
  - miss_count=1; starve back to 0.
- Held request: cpu_req held high through ack with no VGA -> exactly one mem_we per 2 cycles. Back-to-back writes 0x1,0x2 to addrs 4,5 -> acks at cycles 1 and 3.
- Reset mid-op: cpu write granted in the same cycle i_reset=1 -> mem_we=0, next cycle cpu_ack=0, miss_count=0, state=ST_IDLE. A RAM read of that address shows the old value.
- Saturation: MISS_CNT_WIDTH=2, force 5 misses -> miss_count=3 and stays at 3.
